// File: rtl/comfort_pkg.sv
// Shared types and default thresholds for the comfort scheduler.
package comfort_pkg;

  localparam int DEF_SEN_W       = 6;
  localparam int DEF_T_COLD      = 15;
  localparam int DEF_T_HOT       = 30;
  localparam int DEF_HYST        = 2;
  localparam int DEF_LUME_DARK   = 15;
  localparam int DEF_VACANCY_CYC = 8;
  localparam int DEF_MIN_ON      = 4;
  localparam int DEF_DEAD_CYC    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAT = 2'd1,
    COOL = 2'd2,
    DEAD = 2'd3
  } clim_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/occupancy_timer.sv
// Retriggerable occupancy hold-off: occupied stays high VACANCY_CYC cycles after the last motion sample.
module occupancy_timer
  import comfort_pkg::*;
#(
  parameter int VACANCY_CYC = DEF_VACANCY_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic motion_sen,
  output logic occupied
);

  localparam int CW = $clog2(VACANCY_CYC + 1);

  logic [CW-1:0] occ_cnt_q, occ_cnt_d;

  always_comb begin
    occ_cnt_d = occ_cnt_q;
    if (motion_sen)               occ_cnt_d = CW'(VACANCY_CYC);
    else if (occ_cnt_q != '0)     occ_cnt_d = occ_cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) occ_cnt_q <= '0;
    else       occ_cnt_q <= occ_cnt_d;
  end

  assign occupied = (occ_cnt_q != '0);

endmodule

// File: rtl/comfort_scheduler.sv
// Comfort actuator sequencer: occupancy gating, hysteresis thermostat with
// min-on / dead-time interlock, and hysteretic light control.
module comfort_scheduler
  import comfort_pkg::*;
#(
  parameter int SEN_W       = DEF_SEN_W,
  parameter int T_COLD      = DEF_T_COLD,
  parameter int T_HOT       = DEF_T_HOT,
  parameter int HYST        = DEF_HYST,
  parameter int LUME_DARK   = DEF_LUME_DARK,
  parameter int VACANCY_CYC = DEF_VACANCY_CYC,
  parameter int MIN_ON      = DEF_MIN_ON,
  parameter int DEAD_CYC    = DEF_DEAD_CYC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             motion_sen,
  input  logic [SEN_W-1:0] temp_sen,
  input  logic [SEN_W-1:0] lume_sen,
  output logic             heater,
  output logic             cooler,
  output logic             light_high,
  output logic             occupied,
  output logic [1:0]       clim_state
);

  localparam int HW = $clog2(max_int(MIN_ON, DEAD_CYC) + 1);

  localparam logic [SEN_W-1:0] TC_ON   = SEN_W'(T_COLD);
  localparam logic [SEN_W-1:0] TC_OFF  = SEN_W'(T_COLD + HYST);
  localparam logic [SEN_W-1:0] TH_ON   = SEN_W'(T_HOT);
  localparam logic [SEN_W-1:0] TH_OFF  = SEN_W'(T_HOT - HYST);
  localparam logic [SEN_W-1:0] LD_ON   = SEN_W'(LUME_DARK);
  localparam logic [SEN_W-1:0] LD_OFF  = SEN_W'(LUME_DARK + HYST);

  // Band edges must be representable, otherwise the hysteresis silently wraps.
  if (T_COLD + HYST >= (1 << SEN_W) || LUME_DARK + HYST >= (1 << SEN_W) ||
      T_HOT >= (1 << SEN_W) || T_HOT < HYST || T_HOT <= T_COLD + HYST) begin : g_bad_thresh
    $error("comfort_scheduler: threshold/hysteresis configuration out of range");
  end
  if (VACANCY_CYC < 1 || MIN_ON < 1 || DEAD_CYC < 1) begin : g_bad_timing
    $error("comfort_scheduler: VACANCY_CYC, MIN_ON and DEAD_CYC must be >= 1");
  end

  clim_state_t   state_q;
  logic [HW-1:0] hold_q;
  logic          light_q, light_d;

  occupancy_timer #(.VACANCY_CYC(VACANCY_CYC)) u_occ (
    .clk        (clk),
    .reset      (reset),
    .motion_sen (motion_sen),
    .occupied   (occupied)
  );

  // Decisions use the pre-edge occupied flag, so motion shows up on heater two edges later.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (occupied && temp_sen < TC_ON) begin
            state_q <= HEAT;
            hold_q  <= HW'(MIN_ON - 1);
          end else if (occupied && temp_sen > TH_ON) begin
            state_q <= COOL;
            hold_q  <= HW'(MIN_ON - 1);
          end
        end
        HEAT: begin
          if (hold_q != '0) begin
            hold_q <= hold_q - 1'b1;
          end else if (temp_sen >= TC_OFF || !occupied) begin
            state_q <= DEAD;
            hold_q  <= HW'(DEAD_CYC - 1);
          end
        end
        COOL: begin
          if (hold_q != '0) begin
            hold_q <= hold_q - 1'b1;
          end else if (temp_sen <= TH_OFF || !occupied) begin
            state_q <= DEAD;
            hold_q  <= HW'(DEAD_CYC - 1);
          end
        end
        DEAD: begin
          if (hold_q != '0) hold_q  <= hold_q - 1'b1;
          else              state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          hold_q  <= '0;
        end
      endcase
    end
  end

  always_comb begin
    light_d = light_q;
    if (!occupied || lume_sen >= LD_OFF) light_d = 1'b0;
    else if (lume_sen < LD_ON)           light_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) light_q <= 1'b0;
    else       light_q <= light_d;
  end

  assign heater     = (state_q == HEAT);
  assign cooler     = (state_q == COOL);
  assign light_high = light_q;
  assign clim_state = state_q;

endmodule

// File: tb/tb_comfort_scheduler.sv
// Bench for comfort_scheduler: vector table, directed corner sequences, and
// randomized traffic against an age-based reference model.
module tb_comfort_scheduler;

  localparam int VAC = 8, MIN_ON = 4, DEAD_CYC = 2;
  localparam int TC = 15, TH = 30, HY = 2, LD = 15;

  logic       clk = 1'b0;
  logic       reset, motion_sen;
  logic [5:0] temp_sen, lume_sen;
  logic       heater, cooler, light_high, occupied;
  logic [1:0] clim_state;

  int n_chk  = 0;
  int n_fail = 0;

  comfort_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .motion_sen (motion_sen),
    .temp_sen   (temp_sen),
    .lume_sen   (lume_sen),
    .heater     (heater),
    .cooler     (cooler),
    .light_high (light_high),
    .occupied   (occupied),
    .clim_state (clim_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int eo, input int eh, input int ec,
                         input int el, input int es);
    chk({tag, " occupied"},   int'(occupied),   eo);
    chk({tag, " heater"},     int'(heater),     eh);
    chk({tag, " cooler"},     int'(cooler),     ec);
    chk({tag, " light_high"}, int'(light_high), el);
    chk({tag, " clim_state"}, int'(clim_state), es);
    chk({tag, " interlock"},  int'(heater & cooler), 0);
  endtask

  task automatic drive(input logic r, input logic m, input int t, input int l);
    reset      = r;
    motion_sen = m;
    temp_sen   = 6'(t);
    lume_sen   = 6'(l);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: tracks time since last motion and time spent in the current mode.
  int   m_since, m_mode, m_age;
  logic m_light;

  task automatic model_step(input logic r, input logic m, input int t, input int l);
    bit occ;
    if (r) begin
      m_since = VAC; m_mode = 0; m_age = 0; m_light = 1'b0;
      return;
    end
    occ = (m_since < VAC);
    case (m_mode)
      0: if (occ && t < TC) begin m_mode = 1; m_age = 1; end
         else if (occ && t > TH) begin m_mode = 2; m_age = 1; end
      1: if (m_age >= MIN_ON && (t >= TC + HY || !occ)) begin m_mode = 3; m_age = 1; end
         else m_age++;
      2: if (m_age >= MIN_ON && (t <= TH - HY || !occ)) begin m_mode = 3; m_age = 1; end
         else m_age++;
      default: if (m_age >= DEAD_CYC) begin m_mode = 0; m_age = 0; end
               else m_age++;
    endcase
    if (!occ || l >= LD + HY) m_light = 1'b0;
    else if (l < LD)          m_light = 1'b1;
    m_since = m ? 0 : ((m_since < VAC) ? m_since + 1 : VAC);
  endtask

  typedef struct {
    logic rst, mot;
    int   t, l;
    int   o, h, c, li, s;
  } vec_t;

  vec_t tbl[17];

  initial begin
    int occ_cycles;
    int exp_st[7];

    // Warm-up thermostat sequence followed by the light band walk.
    tbl[0]  = '{1'b1, 1'b0, 14, 40, 0, 0, 0, 0, 0};
    tbl[1]  = '{1'b0, 1'b1, 14, 40, 1, 0, 0, 0, 0};
    tbl[2]  = '{1'b0, 1'b1, 14, 40, 1, 1, 0, 0, 1};
    tbl[3]  = '{1'b0, 1'b1, 16, 40, 1, 1, 0, 0, 1};
    tbl[4]  = '{1'b0, 1'b1, 16, 40, 1, 1, 0, 0, 1};
    tbl[5]  = '{1'b0, 1'b1, 16, 40, 1, 1, 0, 0, 1};
    tbl[6]  = '{1'b0, 1'b1, 16, 40, 1, 1, 0, 0, 1};
    tbl[7]  = '{1'b0, 1'b1, 17, 40, 1, 0, 0, 0, 3};
    tbl[8]  = '{1'b0, 1'b1, 17, 40, 1, 0, 0, 0, 3};
    tbl[9]  = '{1'b0, 1'b1, 17, 40, 1, 0, 0, 0, 0};
    tbl[10] = '{1'b0, 1'b1, 17, 40, 1, 0, 0, 0, 0};
    tbl[11] = '{1'b0, 1'b1, 20, 14, 1, 0, 0, 1, 0};
    tbl[12] = '{1'b0, 1'b1, 20, 15, 1, 0, 0, 1, 0};
    tbl[13] = '{1'b0, 1'b1, 20, 16, 1, 0, 0, 1, 0};
    tbl[14] = '{1'b0, 1'b1, 20, 17, 1, 0, 0, 0, 0};
    tbl[15] = '{1'b0, 1'b1, 20, 12, 1, 0, 0, 1, 0};
    tbl[16] = '{1'b1, 1'b0, 20, 12, 0, 0, 0, 0, 0};

    drive(1'b1, 1'b0, 20, 40);
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].rst, tbl[i].mot, tbl[i].t, tbl[i].l);
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].o, tbl[i].h, tbl[i].c, tbl[i].li, tbl[i].s);
    end

    // Hot spike on the first HEAT cycle: min-on, dead time, idle, then cooling.
    exp_st = '{1, 1, 1, 3, 3, 0, 2};
    drive(1'b1, 1'b0, 20, 40); tick();
    drive(1'b0, 1'b1, 14, 40); tick(); tick();
    chk("rev heat entry", int'(heater), 1);
    drive(1'b0, 1'b1, 35, 40);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk_all($sformatf("rev%0d", i), 1, int'(exp_st[i] == 1), int'(exp_st[i] == 2), 0, exp_st[i]);
    end

    // Single motion pulse while hot: occupancy window and cooler drop-out.
    drive(1'b1, 1'b0, 35, 40); tick();
    drive(1'b0, 1'b1, 35, 40); tick();
    occ_cycles = int'(occupied);
    drive(1'b0, 1'b0, 35, 40);
    for (int e = 2; e <= 14; e++) begin
      tick();
      occ_cycles += int'(occupied);
      if (e == 9) begin
        chk("pulse occ fall", int'(occupied), 0);
        chk("pulse cooler held", int'(cooler), 1);
      end
      if (e == 10) begin
        chk("pulse cooler off", int'(cooler), 0);
        chk("pulse dead", int'(clim_state), 3);
      end
      if (e == 12) chk("pulse idle", int'(clim_state), 0);
    end
    chk("pulse occ cycles", occ_cycles, VAC);

    // Reset mid-HEAT, then immediate re-entry without dead time.
    drive(1'b1, 1'b0, 14, 40); tick();
    drive(1'b0, 1'b1, 14, 40); tick(); tick(); tick();
    chk("midrst heat", int'(heater), 1);
    drive(1'b1, 1'b1, 14, 40); tick();
    chk_all("midrst", 0, 0, 0, 0, 0);
    drive(1'b0, 1'b1, 14, 40); tick();
    chk_all("midrst e1", 1, 0, 0, 0, 0);
    tick();
    chk_all("midrst e2", 1, 1, 0, 0, 1);

    // Periodic retrigger in the comfort band.
    drive(1'b1, 1'b0, 21, 40); tick();
    for (int c = 0; c < 60; c++) begin
      drive(1'b0, (c % 5) == 0, 21, 40);
      tick();
      chk_all($sformatf("retrig%0d", c), 1, 0, 0, 0, 0);
    end

    // Randomized traffic against the reference model.
    begin
      int   bias, t, l;
      logic r, m;
      bias = 3;
      for (int i = 0; i < 4000 && n_fail < 20; i++) begin
        if (i % 100 == 0) bias = int'($urandom_range(0, 5));
        r = (i == 0) || ($urandom_range(0, 149) == 0);
        m = ($urandom_range(0, 9) < bias);
        case ($urandom_range(0, 2))
          0:       t = int'($urandom_range(0, 63));
          1:       t = int'($urandom_range(11, 19));
          default: t = int'($urandom_range(26, 34));
        endcase
        l = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(11, 19));
        drive(r, m, t, l);
        model_step(r, m, t, l);
        tick();
        chk_all($sformatf("rnd%0d", i), int'(m_since < VAC), int'(m_mode == 1),
                int'(m_mode == 2), int'(m_light), m_mode);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
